shifter_palette: RTL and testbench
==================================

Name: shifter_palette

Overview:
- Stage directly downstream of the shifter video shift array.
- Converts the 4-bit colour index from the shift array into RGB using the 16-entry palette register file.
- Provides CPU read/write access to the palette at $FF8240-$FF825E.
- Handles border colour, blanking and the monochrome (hi-rez) output path; feeds the video DAC / scan-doubler.

Parameters:
- PAL_ENTRIES, 16, number of palette registers; fixed by the ST architecture, not user-tunable.
- CH_BITS, 4, output bits per colour channel.

Ports:
- clk32  input  1  system clock, 32 MHz
- nReset  input  1  asynchronous active-low reset
- pixClkEn  input  1  pixel clock enable; same strobe that drives the shift array
- DE  input  1  display enable; low = border
- BLANK_n  input  1  active-low blanking
- rez  input  2  resolution: 0 = low, 1 = mid, 2 = high
- monocolor  input  1  1 = mono monitor attached
- color_index  input  4  pixel index from the shift array
- bus_cs  input  1  palette region selected; level, held for the whole access
- bus_rw  input  1  1 = read, 0 = write
- bus_addr  input  4  word address, A[4:1]
- bus_uds  input  1  upper byte strobe, active high
- bus_lds  input  1  lower byte strobe, active high
- bus_din  input  16  CPU write data
- bus_dout  output  16  CPU read data
- bus_dtack  output  1  access acknowledge
- R  output  4  red
- G  output  4  green
- B  output  4  blue

Behaviour:
- Reset values:
  - All palette entries = 0.
  - R, G, B = 0; bus_dout = 0; bus_dtack = 0.
  - Pipeline registers cleared.
- Register layout:
  - Bits [10:8] red, [6:4] green, [2:0] blue.
  - Without the optional feature, other bits read as 0.
- Bus access:
  - A rising edge of bus_cs, detected on clk32, starts one access.
  - Write: on the detection cycle, entry[bus_addr] byte lanes are updated per bus_uds/bus_lds. Both strobes low = no update, dtack is still given.
  - Read: on the detection cycle, bus_dout is loaded with entry[bus_addr]. It holds until the next access.
  - bus_dtack rises one clk32 after detection and stays high while bus_cs is high. It clears on the first clk32 with bus_cs low.
  - bus_cs held high issues no further accesses.
- Pixel pipeline, advancing only on pixClkEn:
  - Stage 1 registers the effective index, DE and BLANK_n. Effective index = color_index if DE, else 0 (border uses entry 0).
  - Stage 2 performs the lookup and drives R/G/B.
  - Latency: 2 pixClkEn ticks from color_index to RGB.
  - Outputs are static between enables.
- Blanking: if the stage-1 copy of BLANK_n is 0, RGB = 0 regardless of palette.
- Monochrome: when rez = 2 and monocolor = 1:
  - pix = color_index[3] XOR entry0[0].
  - R = G = B = pix ? 4'hF : 4'h0.
  - Border in this mode: pix = entry0[0].
  - Blanking still forces 0.
- Colour expansion without the optional feature: 3-bit channel c maps to {c, c[2]}, so 7 → F, 0 → 0, 4 → 9.
- Write/lookup collision: a write and a lookup of the same entry on the same clk32 → the lookup sees the old value. The new value is visible from the next pixClkEn.
- rez = 3: treated as rez = 2.
- Reset asserted mid-access: the access is aborted, dtack drops at once, and the partial write is lost because the entries are reset.

Optional Feature:
- Macro: SHIFTER_STE_PALETTE_EN.
- Defined (STe palette):
  - Nibbles [11:8], [7:4], [3:0] are stored in full; bits [15:12] read as 0.
  - Output channel = {nib[2:0], nib[3]}, i.e. the nibble's MSB is the intensity LSB, giving 4096 colours.
- Undefined (ST palette):
  - Only 3 bits per channel are stored; bit 3 of each nibble reads 0.
  - Channels expand as described in Behaviour.

Decomposition:
- Package shifter_pkg holds:
  - REZ_LOW/REZ_MID/REZ_HIGH constants.
  - PAL_ENTRIES.
  - The channel bit-field positions.
  - The expansion function for 3- or 4-bit channel to 4-bit output.
- One sub-module, shifter_palette_regs:
  - 16-entry register file with byte-lane write.
  - Async-read port for the CPU and one for the pixel path.

Test Plan:
- Reset, then write entry 5 = 16'h0777 (both strobes), then drive index 5 with DE = 1, BLANK_n = 1 → RGB = F,F,F two pixClkEn later; dtack high one clk32 after cs and low after cs drops.
- Write entry 0 = 16'h0700, then drive DE = 0 with any index → RGB = F,0,0 (border). Drive BLANK_n = 0 → RGB = 0,0,0.
- Byte-lane write to entry 3 = 16'h0555, then lds-only write of 16'hFF12 → readback 16'h0512 (ST build).
- Mono mode: rez = 2, monocolor = 1, entry0 = 16'h0001, index 4'b1000 → RGB = 0,0,0; index 0 → F,F,F.
- With SHIFTER_STE_PALETTE_EN: write entry 1 = 16'h0F84, index 1 → R = F, G = 1, B = 8; readback 16'h0F84.
- Collision: write entry 2 on the same clk32 as a pixClkEn that looks up index 2 → old value output that tick, new value on the next tick.

Source files
------------

// File: rtl/shifter_pkg.sv
// shifter_pkg: shared constants, palette field layout and channel expansion for the shifter palette.
// Build option: define SHIFTER_STE_PALETTE_EN for the STe palette (4 stored bits per channel,
// 4096 colours); the default build is the ST palette (3 stored bits per channel, 512 colours).
package shifter_pkg;
    localparam int PAL_ENTRIES = 16;
    localparam int CH_BITS     = 4;
    localparam int IDX_BITS    = $clog2(PAL_ENTRIES);
    localparam int ENTRY_BITS  = 12;
    localparam logic [1:0] REZ_LOW  = 2'd0;
    localparam logic [1:0] REZ_MID  = 2'd1;
    localparam logic [1:0] REZ_HIGH = 2'd2;
    localparam int R_LSB = 8;
    localparam int G_LSB = 4;
    localparam int B_LSB = 0;
`ifdef SHIFTER_STE_PALETTE_EN
    localparam int NIB_BITS = 4;
    localparam logic [ENTRY_BITS-1:0] STORE_MASK = 12'hFFF;
    // The nibble MSB is the intensity LSB, keeping STe palettes ST-compatible.
    function automatic logic [CH_BITS-1:0] expand(input logic [NIB_BITS-1:0] n);
        return {n[2:0], n[3]};
    endfunction
`else
    localparam int NIB_BITS = 3;
    localparam logic [ENTRY_BITS-1:0] STORE_MASK = 12'h777;
    // Replicating the MSB maps 0 -> 0 and 7 -> F so full intensity reaches the DAC rail.
    function automatic logic [CH_BITS-1:0] expand(input logic [NIB_BITS-1:0] n);
        return {n, n[2]};
    endfunction
`endif
endpackage

// File: rtl/shifter_palette_regs.sv
// shifter_palette_regs: 16-entry palette register file with byte-lane writes.
// Ports: clk32/nReset clock and async active-low reset; i_we write strobe; i_addr shared
// CPU write/read address; i_be {upper,lower} byte enables; i_wdata CPU data; o_cpu_rdata
// async CPU read; i_pix_addr/o_pix_rdata async pixel-path read.
// Build option: SHIFTER_STE_PALETTE_EN (via shifter_pkg) widens the stored channel bits.
module shifter_palette_regs
    import shifter_pkg::*;
(
    input  logic                  clk32,
    input  logic                  nReset,
    input  logic                  i_we,
    input  logic [IDX_BITS-1:0]   i_addr,
    input  logic [1:0]            i_be,
    input  logic [15:0]           i_wdata,
    output logic [15:0]           o_cpu_rdata,
    input  logic [IDX_BITS-1:0]   i_pix_addr,
    output logic [ENTRY_BITS-1:0] o_pix_rdata
);
    logic [ENTRY_BITS-1:0] r_entry [PAL_ENTRIES];
    logic [ENTRY_BITS-1:0] w_lane;
    logic                  w_unused;

    // Bits [15:12] are never stored, so the upper lane only covers the red nibble.
    assign w_lane   = {i_be[1] ? 4'hF : 4'h0, i_be[0] ? 8'hFF : 8'h00};
    assign w_unused = ^i_wdata[15:12];

    always_ff @(posedge clk32 or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < PAL_ENTRIES; i++) r_entry[i] <= '0;
        end else if (i_we) begin
            r_entry[i_addr] <= (r_entry[i_addr] & ~w_lane) | (i_wdata[ENTRY_BITS-1:0] & w_lane & STORE_MASK);
        end
    end

    assign o_cpu_rdata = {4'h0, r_entry[i_addr]};
    assign o_pix_rdata = r_entry[i_pix_addr];
endmodule

// File: rtl/shifter_palette.sv
// shifter_palette: colour index to RGB via the palette, with CPU palette access, border,
// blanking and the monochrome path.
// Ports: clk32/nReset clock and async active-low reset; pixClkEn pixel enable; DE display
// enable (low = border); BLANK_n active-low blank; rez resolution; monocolor mono monitor;
// color_index pixel index; bus_cs/bus_rw/bus_addr/bus_uds/bus_lds/bus_din CPU access;
// bus_dout read data; bus_dtack acknowledge; R/G/B 4-bit channels to the DAC.
// Build option: SHIFTER_STE_PALETTE_EN selects the STe 4096-colour palette.
module shifter_palette
    import shifter_pkg::*;
(
    input  logic                clk32,
    input  logic                nReset,
    input  logic                pixClkEn,
    input  logic                DE,
    input  logic                BLANK_n,
    input  logic [1:0]          rez,
    input  logic                monocolor,
    input  logic [IDX_BITS-1:0] color_index,
    input  logic                bus_cs,
    input  logic                bus_rw,
    input  logic [IDX_BITS-1:0] bus_addr,
    input  logic                bus_uds,
    input  logic                bus_lds,
    input  logic [15:0]         bus_din,
    output logic [15:0]         bus_dout,
    output logic                bus_dtack,
    output logic [CH_BITS-1:0]  R,
    output logic [CH_BITS-1:0]  G,
    output logic [CH_BITS-1:0]  B
);
    logic                  r_cs_d;
    logic                  r_dtack;
    logic [15:0]           r_dout;
    logic [IDX_BITS-1:0]   r_s1_idx;
    logic                  r_s1_de;
    logic                  r_s1_blank_n;
    logic [CH_BITS-1:0]    r_r;
    logic [CH_BITS-1:0]    r_g;
    logic [CH_BITS-1:0]    r_b;
    logic                  w_start;
    logic                  w_mono;
    logic                  w_pix;
    logic [IDX_BITS-1:0]   w_pix_addr;
    logic [15:0]           w_cpu_rdata;
    logic [ENTRY_BITS-1:0] w_pix_rdata;

    assign w_start    = bus_cs & ~r_cs_d;
    // rez = 3 behaves as high resolution.
    assign w_mono     = (rez >= REZ_HIGH) & monocolor;
    // Mono only needs entry 0, so the pixel read port is steered there.
    assign w_pix_addr = w_mono ? '0 : r_s1_idx;
    assign w_pix      = (r_s1_de & r_s1_idx[IDX_BITS-1]) ^ w_pix_rdata[0];

    shifter_palette_regs u_regs (
        .clk32       (clk32),
        .nReset      (nReset),
        .i_we        (w_start & ~bus_rw),
        .i_addr      (bus_addr),
        .i_be        ({bus_uds, bus_lds}),
        .i_wdata     (bus_din),
        .o_cpu_rdata (w_cpu_rdata),
        .i_pix_addr  (w_pix_addr),
        .o_pix_rdata (w_pix_rdata)
    );

    // dtack rises the cycle after the edge is seen and follows bus_cs down.
    always_ff @(posedge clk32 or negedge nReset) begin
        if (!nReset) begin
            r_cs_d  <= 1'b0;
            r_dtack <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_cs_d  <= bus_cs;
            r_dtack <= bus_cs & r_cs_d;
            if (w_start & bus_rw) r_dout <= w_cpu_rdata;
        end
    end

    // Stage 2 reads the palette asynchronously at the same edge a write lands, so a
    // colliding lookup sees the old entry value.
    always_ff @(posedge clk32 or negedge nReset) begin
        if (!nReset) begin
            r_s1_idx     <= '0;
            r_s1_de      <= 1'b0;
            r_s1_blank_n <= 1'b0;
            r_r          <= '0;
            r_g          <= '0;
            r_b          <= '0;
        end else if (pixClkEn) begin
            r_s1_idx     <= DE ? color_index : '0;
            r_s1_de      <= DE;
            r_s1_blank_n <= BLANK_n;
            r_r          <= !r_s1_blank_n ? '0 : w_mono ? {CH_BITS{w_pix}} : expand(w_pix_rdata[R_LSB +: NIB_BITS]);
            r_g          <= !r_s1_blank_n ? '0 : w_mono ? {CH_BITS{w_pix}} : expand(w_pix_rdata[G_LSB +: NIB_BITS]);
            r_b          <= !r_s1_blank_n ? '0 : w_mono ? {CH_BITS{w_pix}} : expand(w_pix_rdata[B_LSB +: NIB_BITS]);
        end
    end

    assign bus_dout  = r_dout;
    assign bus_dtack = r_dtack;
    assign R         = r_r;
    assign G         = r_g;
    assign B         = r_b;
endmodule

// File: tb/tb_shifter_palette.sv
// tb_shifter_palette: directed and randomized checks of shifter_palette against a palette model.
module tb_shifter_palette;
    logic        clk32 = 0, nReset = 0, pixClkEn = 0, DE = 0, BLANK_n = 0, monocolor = 0;
    logic        bus_cs = 0, bus_rw = 1, bus_uds = 0, bus_lds = 0, bus_dtack;
    logic [1:0]  rez = 0;
    logic [3:0]  color_index = 0, bus_addr = 0, R, G, B;
    logic [15:0] bus_din = 0, bus_dout, rgb, last_rgb = 0;

    always #5 clk32 = ~clk32;
    assign rgb = {4'h0, R, G, B};

    shifter_palette dut (
        .clk32(clk32), .nReset(nReset), .pixClkEn(pixClkEn), .DE(DE), .BLANK_n(BLANK_n),
        .rez(rez), .monocolor(monocolor), .color_index(color_index), .bus_cs(bus_cs),
        .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_uds(bus_uds), .bus_lds(bus_lds),
        .bus_din(bus_din), .bus_dout(bus_dout), .bus_dtack(bus_dtack), .R(R), .G(G), .B(B)
    );

    typedef struct {
        logic [3:0] idx;
        logic       bl;
    } pix_t;

    pix_t        q[$];
    logic [15:0] pal [16];
    int          n_checks = 0, n_errors = 0;
`ifdef SHIFTER_STE_PALETTE_EN
    localparam logic [15:0] MASK = 16'h0FFF;
`else
    localparam logic [15:0] MASK = 16'h0777;
`endif

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int chan(input int n);
`ifdef SHIFTER_STE_PALETTE_EN
        return (n % 8) * 2 + n / 8;
`else
        int c;
        c = n % 8;
        return c * 2 + c / 4;
`endif
    endfunction

    function automatic logic [15:0] ref_rgb(input pix_t p);
        int w, px;
        if (!p.bl) return 16'h0;
        if (rez >= 2 && monocolor) begin
            px = (int'(p.idx) / 8) ^ (int'(pal[0]) % 2);
            return px != 0 ? 16'h0FFF : 16'h0;
        end
        w = int'(pal[p.idx]);
        return 16'(chan((w / 256) % 16) * 256 + chan((w / 16) % 16) * 16 + chan(w % 16));
    endfunction

    task automatic model_write(input logic [3:0] a, input logic [15:0] d, input logic u, input logic l);
        if (u) pal[a][15:8] = d[15:8];
        if (l) pal[a][7:0] = d[7:0];
        pal[a] = pal[a] & MASK;
    endtask

    task automatic model_reset();
        pix_t z;
        for (int i = 0; i < 16; i++) pal[i] = 16'h0;
        z.idx = 0;
        z.bl  = 0;
        q.delete();
        q.push_back(z);
        last_rgb = 16'h0;
    endtask

    task automatic do_reset();
        nReset = 0;
        bus_cs = 0;
        pixClkEn = 0;
        repeat (2) @(negedge clk32);
        model_reset();
        check("rst_rgb", rgb, 16'h0);
        check("rst_dout", bus_dout, 16'h0);
        check("rst_dtack", bus_dtack, 1'b0);
        nReset = 1;
        @(negedge clk32);
    endtask

    // Called and returning on a falling edge; one pixel tick, optionally with a colliding write.
    task automatic pix_tick(input logic [3:0] idx, input logic de, input logic bl,
                            input logic wr = 0, input logic [3:0] wa = 0, input logic [15:0] wd = 0);
        pix_t p, old;
        logic [15:0] exp;
        color_index = idx;
        DE = de;
        BLANK_n = bl;
        pixClkEn = 1;
        if (wr) begin
            bus_cs = 1; bus_rw = 0; bus_addr = wa; bus_din = wd; bus_uds = 1; bus_lds = 1;
        end
        p.idx = de ? idx : 4'h0;
        p.bl  = bl;
        q.push_back(p);
        old = q.pop_front();
        exp = ref_rgb(old);
        if (wr) model_write(wa, wd, 1'b1, 1'b1);
        @(posedge clk32);
        @(negedge clk32);
        pixClkEn = 0;
        bus_cs = 0;
        check("rgb", rgb, exp);
        last_rgb = exp;
        if (wr) @(negedge clk32);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] d, input logic u = 1, input logic l = 1);
        bus_cs = 1; bus_rw = 0; bus_addr = a; bus_din = d; bus_uds = u; bus_lds = l;
        @(posedge clk32);
        model_write(a, d, u, l);
        @(negedge clk32);
        check("dtack_detect", bus_dtack, 1'b0);
        bus_din = ~d;
        @(negedge clk32);
        check("dtack_high", bus_dtack, 1'b1);
        @(negedge clk32);
        check("dtack_hold", bus_dtack, 1'b1);
        bus_cs = 0;
        @(negedge clk32);
        check("dtack_clear", bus_dtack, 1'b0);
        check("rgb_static", rgb, last_rgb);
    endtask

    task automatic bus_read(input logic [3:0] a);
        bus_cs = 1; bus_rw = 1; bus_addr = a;
        @(negedge clk32);
        check("read", bus_dout, pal[a]);
        @(negedge clk32);
        bus_cs = 0;
        bus_addr = ~a;
        @(negedge clk32);
        check("read_hold", bus_dout, pal[a]);
    endtask

    initial begin
        @(negedge clk32);
        do_reset();

        bus_write(4'd5, 16'h0777);
        pix_tick(4'd5, 1, 1);
        pix_tick(4'd5, 1, 1);
        check("white", rgb, 16'h0FFF);

        bus_write(4'd0, 16'h0700);
        pix_tick(4'd9, 0, 1);
        pix_tick(4'd9, 0, 1);
        check("border_red", rgb, 16'h0F00);
        pix_tick(4'd5, 1, 0);
        pix_tick(4'd5, 1, 1);
        check("blanked", rgb, 16'h0000);

        bus_write(4'd3, 16'h0555);
        bus_write(4'd3, 16'hFF12, 1'b0, 1'b1);
        bus_read(4'd3);
        check("lds_only", bus_dout, 16'h0512);
        bus_write(4'd3, 16'hABCD, 1'b0, 1'b0);
        bus_read(4'd3);

        bus_write(4'd1, 16'h0F84);
        bus_read(4'd1);
        pix_tick(4'd1, 1, 1);
        pix_tick(4'd1, 1, 1);
`ifdef SHIFTER_STE_PALETTE_EN
        check("ste_read", bus_dout, 16'h0F84);
        check("ste_rgb", rgb, 16'h0F18);
`else
        check("st_read", bus_dout, 16'h0704);
        check("st_rgb", rgb, 16'h0F09);
`endif

        bus_write(4'd2, 16'h0007);
        pix_tick(4'd2, 1, 1);
        pix_tick(4'd2, 1, 1, 1, 4'd2, 16'h0700);
        check("collide_old", rgb, 16'h000F);
        pix_tick(4'd2, 1, 1);
        check("collide_new", rgb, 16'h0F00);

        rez = 2; monocolor = 1;
        bus_write(4'd0, 16'h0001);
        pix_tick(4'd8, 1, 1);
        pix_tick(4'd8, 1, 1);
        check("mono_dark", rgb, 16'h0000);
        pix_tick(4'd0, 1, 1);
        pix_tick(4'd0, 1, 1);
        check("mono_white", rgb, 16'h0FFF);
        rez = 3;
        pix_tick(4'd7, 0, 1);
        pix_tick(4'd7, 0, 0);
        check("mono_border", rgb, 16'h0FFF);
        pix_tick(4'd7, 0, 1);
        check("mono_blank", rgb, 16'h0000);
        rez = 0; monocolor = 0;

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 4))
                0: bus_write(4'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                1: bus_read(4'($urandom));
                2: pix_tick(4'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'b1, 4'($urandom), 16'($urandom));
                default: begin
                    if ($urandom_range(0, 7) == 0) begin
                        rez = 2'($urandom);
                        monocolor = 1'($urandom);
                    end
                    pix_tick(4'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
                end
            endcase
        end

        bus_cs = 1; bus_rw = 0; bus_addr = 4'd7; bus_din = 16'h0123; bus_uds = 1; bus_lds = 1;
        @(negedge clk32);
        @(negedge clk32);
        check("abort_dtack_pre", bus_dtack, 1'b1);
        #2 nReset = 0;
        #1 check("abort_dtack", bus_dtack, 1'b0);
        @(negedge clk32);
        bus_cs = 0;
        model_reset();
        check("abort_rgb", rgb, 16'h0);
        nReset = 1;
        @(negedge clk32);
        bus_read(4'd7);
        bus_read(4'd5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
